// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - value load and digit drive signals of the seven-segment scanner
interface display_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  blank_lz;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     digit_en;
    logic                  pending;
    logic                  frame_tick;

    modport master (
        output load, value, blank_lz,
        input  nibble, digit_en, pending, frame_tick
    );

    modport slave (
        input  load, value, blank_lz,
        output nibble, digit_en, pending, frame_tick
    );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed common-anode digit scanner with frame-aligned commit
// Feeds one nibble per slot to the hex decoder and drives the matching active-low digit enable.
module display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input logic              clk,
    input logic              rst,
    display_scanner_if.slave bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]      pre;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   shadow;
    logic                  pendingQ;
    logic                  preWrap;
    logic                  frameTick;
    logic                  zeroRun;
    logic [DIGITS-1:0]     blanked;
    logic [3:0]            nibbleSel;
    logic [DIGITS-1:0]     enSel;

    assign preWrap   = (pre == PRE_LAST);
    assign frameTick = preWrap && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            idx      <= '0;
            disp     <= '0;
            shadow   <= '0;
            pendingQ <= 1'b0;
        end else begin
            pre <= preWrap ? '0 : pre + PRE_W'(1);
            if (preWrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            // disp only moves on the frame boundary so a frame never mixes two values
            if (bus.load && frameTick) begin
                disp     <= bus.value;
                shadow   <= bus.value;
                pendingQ <= 1'b0;
            end else if (frameTick && pendingQ) begin
                disp     <= shadow;
                pendingQ <= 1'b0;
            end else if (bus.load) begin
                shadow   <= bus.value;
                pendingQ <= 1'b1;
            end
        end
    end

    always_comb begin
        zeroRun   = 1'b1;
        blanked   = '0;
        nibbleSel = 4'h0;
        enSel     = '1;
        // walk down from the top digit; a digit blanks while everything above it is zero
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeroRun    = zeroRun && (disp[4*i +: 4] == 4'h0);
            blanked[i] = bus.blank_lz && (i != 0) && zeroRun;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibbleSel = disp[4*i +: 4];
                if ((pre != '0) && !blanked[i]) begin
                    enSel[i] = 1'b0;
                end
            end
        end
    end

    assign bus.nibble     = nibbleSel;
    assign bus.digit_en   = enSel;
    assign bus.pending    = pendingQ;
    assign bus.frame_tick = frameTick;
endmodule
